hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Producer-side hazard controller of the 5-stage pipeline (IF ID EX MEM WB).
//  - Operand bypass from MEM/WB is handled in the datapath.
//  - This block resolves everything bypass cannot: load-use stalls, taken-branch flushes, data-memory wait states.
//  - Drives stall/bubble/flush enables of all pipeline registers.
//  - Runs a memory-wait FSM with a timeout watchdog.
// PARAMETERS
//  MEM_TIMEOUT  16  max consecutive wait cycles before MemErr; must be >= 1
//  CNT_W        32  width of perf counters (HAZARD_PERF_EN only)
// PORTS
//  clk          in   1      pipeline clock; all state on rising edge
//  rst          in   1      asynchronous, active-high reset
//  Rs1AddrD     in   5      ID-stage source 1 register address
//  Rs1UsedD     in   1      ID instruction reads Rs1
//  Rs2AddrD     in   5      ID-stage source 2 register address
//  Rs2UsedD     in   1      ID instruction reads Rs2
//  AddrD3       in   5      EX-stage destination register
//  RDValid3     in   1      EX-stage instruction writes a register
//  WBSel3       in   1      EX-stage write-back source: 1=ALU, 0=memory (load)
//  BranchTaken3 in   1      branch/jump resolved taken in EX
//  MemReq4      in   1      MEM-stage instruction accesses data memory
//  MemReady     in   1      data memory completes access this cycle
//  StallIF      out  1      hold PC
//  StallID      out  1      hold IF/ID register
//  FlushID      out  1      clear IF/ID register to NOP
//  StallEX      out  1      hold ID/EX register
//  BubbleEX     out  1      load NOP into ID/EX register
//  StallMEM     out  1      hold EX/MEM register
//  BubbleWB     out  1      load NOP into MEM/WB register
//  MemErr       out  1      one-cycle pulse: memory wait timed out
// BEHAVIOUR
//  - Outputs are combinational from state + inputs (same-cycle effect). State is registered.
//  - Reset (rst=1, async): state=RUN, WaitCnt=0, MemErr=0.
//    While rst=1, BubbleEX=FlushID=BubbleWB=1 and all Stall*=0.
//  - LoadUse = RDValid3 & ~WBSel3 & (AddrD3!=0) & ((Rs1UsedD & Rs1AddrD==AddrD3) | (Rs2UsedD & Rs2AddrD==AddrD3)).
//  - MemBusy = MemReq4 & ~MemReady.
//  - FSM states: RUN, MEM_WAIT.
//    - RUN -> MEM_WAIT when MemBusy. WaitCnt loads 1.
//    - MEM_WAIT -> RUN when MemReady, or when WaitCnt==MEM_TIMEOUT.
//      Timeout fires a one-cycle MemErr pulse and the access is treated as complete.
//    - Otherwise WaitCnt increments. WaitCnt returns to 0 on exit.
//  - Freeze condition = MemBusy & no timeout this cycle (RUN or MEM_WAIT).
//    - Asserts StallIF, StallID, StallEX, StallMEM and BubbleWB, so no write-back repeats.
//    - FlushID=BubbleEX=0: a branch or load-use in EX/ID waits until the freeze ends.
//  - Priority when not frozen: BranchTaken3 > LoadUse.
//    - BranchTaken3: FlushID=1, BubbleEX=1 for exactly one cycle. PC not stalled (loads target).
//      A coincident LoadUse is ignored because the dependent instruction is squashed.
//    - LoadUse: StallIF=StallID=1, BubbleEX=1 for one cycle.
//      Next cycle the load is in MEM and the bypass supplies its data.
//  - Register x0 never causes a hazard.
//  - MemReady without MemReq4 is ignored.
// CONFIGURATION
//  HAZARD_PERF_EN defined:
//    - adds outputs StallCycles, FlushCount, TimeoutCount [CNT_W-1:0].
//    - StallCycles: +1 every cycle StallIF=1.
//    - FlushCount: +1 per FlushID.
//    - TimeoutCount: +1 per MemErr.
//    - All counters saturate at max value and reset to 0.
//  HAZARD_PERF_EN undefined: ports absent, no counters synthesised.
// TESTING
//  - lw x5 in EX, ID add x6,x5,x1 (Rs1Used) -> 1 cycle StallIF/StallID/BubbleEX=1; next cycle all 0.
//  - lw x0 in EX, ID reads x0 -> no stall; lw x5 in EX, ID reads x5 only via Rs2 with Rs2Used=0 -> no stall.
//  - BranchTaken3=1 with simultaneous LoadUse -> FlushID=BubbleEX=1, StallIF=0, single cycle.
//  - MemReq4=1, MemReady low 3 cycles then high -> Stall* and BubbleWB high exactly 3 cycles; MemErr never.
//  - MEM_TIMEOUT=4, MemReady held 0 -> freeze for the cycles in which WaitCnt<4.
//    On WaitCnt==4: MemErr pulses one cycle, freeze released, FSM returns to RUN.
//  - rst asserted mid MEM_WAIT -> immediately RUN, WaitCnt=0, BubbleEX=FlushID=BubbleWB=1;
//    with HAZARD_PERF_EN, counters read 0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage pipeline: load-use stalls, branch flushes, memory-wait freeze.
// Optional performance counters are enabled with `define HAZARD_PERF_EN.
module hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] Rs1AddrD,
    input  logic       Rs1UsedD,
    input  logic [4:0] Rs2AddrD,
    input  logic       Rs2UsedD,
    input  logic [4:0] AddrD3,
    input  logic       RDValid3,
    input  logic       WBSel3,
    input  logic       BranchTaken3,
    input  logic       MemReq4,
    input  logic       MemReady,
    output logic       StallIF,
    output logic       StallID,
    output logic       FlushID,
    output logic       StallEX,
    output logic       BubbleEX,
    output logic       StallMEM,
    output logic       BubbleWB,
    output logic       MemErr
`ifdef HAZARD_PERF_EN
    ,
    output logic [CNT_W-1:0] StallCycles,
    output logic [CNT_W-1:0] FlushCount,
    output logic [CNT_W-1:0] TimeoutCount
`endif
);

    localparam int unsigned CntW = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [CntW-1:0] TimeoutVal = CntW'(MEM_TIMEOUT);

    typedef enum logic [0:0] {StRun, StMemWait} state_e;

    state_e          r_state;
    state_e          w_state_d;
    logic [CntW-1:0] r_wait_cnt;
    logic [CntW-1:0] w_wait_cnt_d;

    logic w_load_use;
    logic w_mem_busy;
    logic w_timeout;
    logic w_freeze;

    assign w_load_use = RDValid3 & ~WBSel3 & (AddrD3 != 5'd0) &
                        ((Rs1UsedD & (Rs1AddrD == AddrD3)) | (Rs2UsedD & (Rs2AddrD == AddrD3)));
    assign w_mem_busy = MemReq4 & ~MemReady;
    assign w_timeout  = (r_state == StMemWait) & w_mem_busy & (r_wait_cnt == TimeoutVal);
    assign w_freeze   = w_mem_busy & ~w_timeout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= StRun;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_d;
            r_wait_cnt <= w_wait_cnt_d;
        end
    end

    always_comb begin
        w_state_d    = r_state;
        w_wait_cnt_d = r_wait_cnt;
        unique case (r_state)
            StRun: begin
                if (w_mem_busy) begin
                    w_state_d    = StMemWait;
                    w_wait_cnt_d = CntW'(1);
                end
            end
            StMemWait: begin
                // A timeout is treated as a completed access so the pipeline can drain.
                if (!w_mem_busy || w_timeout) begin
                    w_state_d    = StRun;
                    w_wait_cnt_d = '0;
                end else begin
                    w_wait_cnt_d = r_wait_cnt + CntW'(1);
                end
            end
            default: begin
                w_state_d    = StRun;
                w_wait_cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        StallIF  = 1'b0;
        StallID  = 1'b0;
        FlushID  = 1'b0;
        StallEX  = 1'b0;
        BubbleEX = 1'b0;
        StallMEM = 1'b0;
        BubbleWB = 1'b0;
        MemErr   = 1'b0;
        if (rst) begin
            FlushID  = 1'b1;
            BubbleEX = 1'b1;
            BubbleWB = 1'b1;
        end else begin
            MemErr = w_timeout;
            if (w_freeze) begin
                // Whole pipe holds; MEM/WB takes a bubble so no write-back repeats.
                StallIF  = 1'b1;
                StallID  = 1'b1;
                StallEX  = 1'b1;
                StallMEM = 1'b1;
                BubbleWB = 1'b1;
            end else if (BranchTaken3) begin
                FlushID  = 1'b1;
                BubbleEX = 1'b1;
            end else if (w_load_use) begin
                StallIF  = 1'b1;
                StallID  = 1'b1;
                BubbleEX = 1'b1;
            end
        end
    end

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] r_stall_cycles;
    logic [CNT_W-1:0] r_flush_count;
    logic [CNT_W-1:0] r_timeout_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cycles  <= '0;
            r_flush_count   <= '0;
            r_timeout_count <= '0;
        end else begin
            if (StallIF && (r_stall_cycles != {CNT_W{1'b1}})) begin
                r_stall_cycles <= r_stall_cycles + CNT_W'(1);
            end
            if (FlushID && (r_flush_count != {CNT_W{1'b1}})) begin
                r_flush_count <= r_flush_count + CNT_W'(1);
            end
            if (MemErr && (r_timeout_count != {CNT_W{1'b1}})) begin
                r_timeout_count <= r_timeout_count + CNT_W'(1);
            end
        end
    end

    assign StallCycles  = r_stall_cycles;
    assign FlushCount   = r_flush_count;
    assign TimeoutCount = r_timeout_count;
`else
    logic w_unused_cnt_w;
    assign w_unused_cnt_w = (CNT_W == 0);
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: vector table, hand sequences, randomized model comparison.
module tb_hazard_ctrl;

    localparam int unsigned TO = 4;

    typedef struct packed {
        logic [4:0] rs1;
        logic       u1;
        logic [4:0] rs2;
        logic       u2;
        logic [4:0] rd;
        logic       rdv;
        logic       wbsel;
        logic       br;
        logic       mreq;
        logic       mrdy;
    } in_t;

    typedef struct packed {
        in_t        in;
        logic [7:0] exp;
    } vec_t;

    // {StallIF, StallID, FlushID, StallEX, BubbleEX, StallMEM, BubbleWB, MemErr}
    localparam logic [7:0] NONE = 8'b0000_0000;
    localparam logic [7:0] LU   = 8'b1100_1000;
    localparam logic [7:0] BR   = 8'b0010_1000;
    localparam logic [7:0] FRZ  = 8'b1101_0110;
    localparam logic [7:0] ERR  = 8'b0000_0001;
    localparam logic [7:0] RST  = 8'b0010_1010;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] Rs1AddrD = '0, Rs2AddrD = '0, AddrD3 = '0;
    logic       Rs1UsedD = 0, Rs2UsedD = 0, RDValid3 = 0, WBSel3 = 0;
    logic       BranchTaken3 = 0, MemReq4 = 0, MemReady = 0;
    logic       StallIF, StallID, FlushID, StallEX, BubbleEX, StallMEM, BubbleWB, MemErr;
`ifdef HAZARD_PERF_EN
    logic [31:0] StallCycles, FlushCount, TimeoutCount;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int m_k     = 0;

    hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .Rs1AddrD(Rs1AddrD), .Rs1UsedD(Rs1UsedD), .Rs2AddrD(Rs2AddrD), .Rs2UsedD(Rs2UsedD),
        .AddrD3(AddrD3), .RDValid3(RDValid3), .WBSel3(WBSel3), .BranchTaken3(BranchTaken3),
        .MemReq4(MemReq4), .MemReady(MemReady),
        .StallIF(StallIF), .StallID(StallID), .FlushID(FlushID), .StallEX(StallEX),
        .BubbleEX(BubbleEX), .StallMEM(StallMEM), .BubbleWB(BubbleWB), .MemErr(MemErr)
`ifdef HAZARD_PERF_EN
        , .StallCycles(StallCycles), .FlushCount(FlushCount), .TimeoutCount(TimeoutCount)
`endif
    );

    always #5 clk = ~clk;

    wire [7:0] w_out = {StallIF, StallID, FlushID, StallEX, BubbleEX, StallMEM, BubbleWB, MemErr};

    task automatic drive(input in_t v);
        Rs1AddrD = v.rs1; Rs1UsedD = v.u1; Rs2AddrD = v.rs2; Rs2UsedD = v.u2;
        AddrD3 = v.rd; RDValid3 = v.rdv; WBSel3 = v.wbsel; BranchTaken3 = v.br;
        MemReq4 = v.mreq; MemReady = v.mrdy;
    endtask

    task automatic chk(input logic [7:0] exp, input string nm);
        n_tests++;
        if (w_out !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", nm, w_out, exp);
        end
    endtask

    task automatic cyc(input in_t v, input logic [7:0] exp, input string nm);
        @(posedge clk);
        #1 drive(v);
        @(negedge clk);
        chk(exp, nm);
    endtask

    // Reference: k counts consecutive frozen memory cycles; the access times out once k reaches TO.
    function automatic logic [7:0] model(input in_t v, input int k);
        logic busy, to, lu;
        busy = v.mreq && !v.mrdy;
        to   = busy && (k == TO);
        lu   = v.rdv && !v.wbsel && (v.rd != 0) &&
               ((v.u1 && v.rs1 == v.rd) || (v.u2 && v.rs2 == v.rd));
        if (busy && !to) return FRZ;
        if (v.br)        return BR | {7'b0, to};
        if (lu)          return LU | {7'b0, to};
        return {7'b0, to};
    endfunction

    function automatic int next_k(input in_t v, input int k);
        if (v.mreq && !v.mrdy && k != TO) return k + 1;
        return 0;
    endfunction

    vec_t tbl[14];
    in_t  idle, busy, rdy;

    initial begin
        idle = '0;
        busy = '0; busy.mreq = 1'b1;
        rdy  = busy; rdy.mrdy = 1'b1;

        //           rs1 u1 rs2 u2  rd rdv wb br mq mr
        tbl[0]  = '{'{5'd5, 1, 5'd1, 1, 5'd5, 1, 0, 0, 0, 0}, LU};
        tbl[1]  = '{'{5'd0, 1, 5'd0, 1, 5'd0, 1, 0, 0, 0, 0}, NONE};
        tbl[2]  = '{'{5'd1, 1, 5'd5, 0, 5'd5, 1, 0, 0, 0, 0}, NONE};
        tbl[3]  = '{'{5'd1, 1, 5'd5, 1, 5'd5, 1, 0, 0, 0, 0}, LU};
        tbl[4]  = '{'{5'd5, 1, 5'd5, 1, 5'd5, 1, 1, 0, 0, 0}, NONE};
        tbl[5]  = '{'{5'd5, 1, 5'd5, 1, 5'd5, 0, 0, 0, 0, 0}, NONE};
        tbl[6]  = '{'{5'd5, 1, 5'd0, 0, 5'd5, 1, 0, 1, 0, 0}, BR};
        tbl[7]  = '{'{5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 1, 0, 0}, BR};
        tbl[8]  = '{'{5'd6, 1, 5'd7, 1, 5'd5, 1, 0, 0, 0, 0}, NONE};
        tbl[9]  = '{'{5'd5, 1, 5'd0, 0, 5'd5, 1, 0, 0, 0, 1}, LU};
        tbl[10] = '{'{5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 1, 1, 1}, BR};
        tbl[11] = '{'{5'd5, 1, 5'd0, 0, 5'd5, 1, 0, 1, 1, 0}, FRZ};
        tbl[12] = '{'{5'd5, 1, 5'd0, 0, 5'd5, 1, 0, 0, 1, 1}, LU};
        tbl[13] = '{'{5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 0}, NONE};

        // Reset state
        drive(idle);
        #2 chk(RST, "reset_outputs");
`ifdef HAZARD_PERF_EN
        n_tests++;
        if (StallCycles != 0 || FlushCount != 0 || TimeoutCount != 0) begin
            n_fail++;
            $display("FAIL reset_counters: got %0d/%0d/%0d expected 0/0/0",
                     StallCycles, FlushCount, TimeoutCount);
        end
`endif
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 14; i++) cyc(tbl[i].in, tbl[i].exp, $sformatf("vec%0d", i));

        // Load-use lasts one cycle: next cycle EX holds the bubble
        cyc(tbl[0].in, LU, "lu_first");
        cyc(idle, NONE, "lu_released");

        // Three wait states then ready
        for (int i = 0; i < 3; i++) cyc(busy, FRZ, $sformatf("wait3_c%0d", i));
        cyc(rdy, NONE, "wait3_ready");
        cyc(idle, NONE, "wait3_after");

        // Timeout: freeze while count < TO, then one MemErr cycle, then a fresh access
        for (int i = 0; i < TO; i++) cyc(busy, FRZ, $sformatf("to_frz%0d", i));
        cyc(busy, ERR, "to_err");
        cyc(busy, FRZ, "to_restart");
        cyc(rdy, NONE, "to_done");

        // Reset in the middle of a wait
        cyc(busy, FRZ, "rstmid_a");
        cyc(busy, FRZ, "rstmid_b");
        rst = 1'b1;
        #1 chk(RST, "rstmid_outputs");
`ifdef HAZARD_PERF_EN
        n_tests++;
        if (StallCycles != 0 || FlushCount != 0 || TimeoutCount != 0) begin
            n_fail++;
            $display("FAIL rstmid_counters: got %0d/%0d/%0d expected 0/0/0",
                     StallCycles, FlushCount, TimeoutCount);
        end
`endif
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk(FRZ, "rstmid_run0");
        for (int i = 1; i < TO; i++) cyc(busy, FRZ, $sformatf("rstmid_frz%0d", i));
        cyc(busy, ERR, "rstmid_err");

        // Randomized against the reference model
        m_k = 0;
        for (int i = 0; i < 600; i++) begin
            in_t v;
            logic [7:0] e;
            v.rs1   = 5'($urandom_range(0, 3));
            v.u1    = 1'($urandom);
            v.rs2   = 5'($urandom_range(0, 3));
            v.u2    = 1'($urandom);
            v.rd    = 5'($urandom_range(0, 3));
            v.rdv   = 1'($urandom);
            v.wbsel = 1'($urandom);
            v.br    = ($urandom_range(0, 4) == 0);
            v.mreq  = ($urandom_range(0, 2) != 0);
            v.mrdy  = ($urandom_range(0, 3) == 0);
            e = model(v, m_k);
            cyc(v, e, $sformatf("rand%0d", i));
            m_k = next_k(v, m_k);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
